guia_0502_sweep: RTL and testbench

- Parametrised, registered two-operand bitwise logic unit with a selectable gate function.
- Stream mode: operand pairs enter over a valid/ready handshake; results leave registered over a valid/ready handshake.
- Sweep mode: the block generates every (a,b) combination in truth-table order, emits each result, and reports a popcount total at the end.
- It sits where the single-gate Guia_05xx blocks sit and replaces their fixed 1-bit gate with a clocked, width-generic unit.

---
 rtl/guia_0502_sweep.sv | 155 +++++++++++++++
 tb/tb_guia_0502_sweep.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/guia_0502_sweep.sv
// Registered two-operand bitwise logic unit with a valid/ready stream mode and a
// self-driven truth-table sweep mode that totals the 1 bits of every swept result.
module guia_0502_sweep #(
  parameter  int WIDTH = 2,
  localparam int SUMW  = 2*WIDTH + $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [SUMW-1:0]  sum
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2*WIDTH-1:0] CNT_LAST = {(2*WIDTH){1'b1}};
  localparam logic [2*WIDTH-1:0] CNT_ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [2*WIDTH-1:0] cnt_r;
  logic [2:0]         op_r;
  logic               slot_free_s;
  logic [WIDTH-1:0]   sw_a_s;
  logic [WIDTH-1:0]   sw_b_s;
  logic [WIDTH-1:0]   sw_s_s;

  // Inverted gates rely on the WIDTH-bit return type to drop bits above the operand.
  function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] sel,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    case (sel)
      3'd0:    gate_f = x & y;
      3'd1:    gate_f = x | y;
      3'd2:    gate_f = ~(x & y);
      3'd3:    gate_f = ~(x | y);
      3'd4:    gate_f = x ^ y;
      3'd5:    gate_f = ~(x ^ y);
      3'd6:    gate_f = x & ~y;
      3'd7:    gate_f = ~x | y;
      default: gate_f = {WIDTH{1'b0}};
    endcase
  endfunction

  function automatic logic [SUMW-1:0] popcount_f(input logic [WIDTH-1:0] v);
    popcount_f = {SUMW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      popcount_f = popcount_f + {{(SUMW-1){1'b0}}, v[i]};
    end
  endfunction

  // Handshake readiness and the sweep operand pair decoded from the counter.
  always_comb begin
    slot_free_s = !out_valid | out_ready;
    if (state_r == IDLE) begin
      in_ready = slot_free_s & !start;
    end else begin
      in_ready = 1'b0;
    end
    sw_a_s = cnt_r[2*WIDTH-1:WIDTH];
    sw_b_s = cnt_r[WIDTH-1:0];
    sw_s_s = gate_f(op_r, sw_a_s, sw_b_s);
  end

  // Mode FSM together with the output register, sweep counter and popcount total.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {(2*WIDTH){1'b0}};
      op_r      <= 3'd0;
      s         <= {WIDTH{1'b0}};
      a_o       <= {WIDTH{1'b0}};
      b_o       <= {WIDTH{1'b0}};
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= {SUMW{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            // start takes priority: no pair is accepted on this edge
            op_r    <= op;
            cnt_r   <= {(2*WIDTH){1'b0}};
            sum     <= {SUMW{1'b0}};
            state_r <= SWEEP;
            busy    <= 1'b1;
            if (out_ready) begin
              out_valid <= 1'b0;
            end else begin
              out_valid <= out_valid;
            end
          end else if (in_valid && in_ready) begin
            s         <= gate_f(op, a, b);
            a_o       <= a;
            b_o       <= b;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end else begin
            out_valid <= out_valid;
          end
        end
        SWEEP: begin
          if (slot_free_s) begin
            s         <= sw_s_s;
            a_o       <= sw_a_s;
            b_o       <= sw_b_s;
            out_valid <= 1'b1;
            sum       <= sum + popcount_f(sw_s_s);
            cnt_r     <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_LAST) begin
              state_r <= DRAIN;
            end else begin
              state_r <= SWEEP;
            end
          end else begin
            out_valid <= out_valid;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end else begin
            out_valid <= out_valid;
          end
        end
        default: begin
          state_r   <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_guia_0502_sweep.sv
// Randomised self-checking bench for guia_0502_sweep (WIDTH=2) using a truth-table
// reference model and a result queue scoreboard.
module tb_guia_0502_sweep;

  localparam int W    = 2;
  localparam int SUMW = 2*W + $clog2(W) + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      op;
  logic            start;
  logic [W-1:0]    a, b;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    s, a_o, b_o;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            done;
  logic [SUMW-1:0] sum;

  int tests = 0;
  int fails = 0;

  // Truth table per gate, indexed by {a_bit, b_bit}.
  logic [3:0] tt [8];

  guia_0502_sweep #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .start(start), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .s(s), .a_o(a_o), .b_o(b_o),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .sum(sum)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_f(input int o, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic [3:0] row;
    row = tt[o];
    for (int i = 0; i < W; i++) model_f[i] = row[{x[i], y[i]}];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = 3'd0; start = 1'b0; a = '0; b = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    #12;
    tests++;
    if ({s, a_o, b_o, out_valid, busy, done, sum} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got s=%0d a_o=%0d b_o=%0d ov=%0b busy=%0b done=%0b sum=%0d want all 0",
               s, a_o, b_o, out_valid, busy, done, sum);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream();
    op = 3'd0; a = 2'b10; b = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++; $display("FAIL stream_in_ready got %0b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, s, a_o, b_o} !== {1'b1, 2'b10, 2'b10, 2'b11}) begin
      fails++;
      $display("FAIL stream_first got ov=%0b s=%0d a_o=%0d b_o=%0d want 1 2 2 3",
               out_valid, s, a_o, b_o);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL stream_clear got ov=%0b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    int po;
    po = 4;
    for (int i = 0; i < 3; i++) begin pa[i] = W'($urandom); pb[i] = W'($urandom); end
    op = 3'(po); out_ready = 1'b0;
    a = pa[0]; b = pb[0]; in_valid = 1'b1;
    tick();
    a = pa[1]; b = pb[1];
    for (int c = 0; c < 3; c++) begin
      tests++;
      if ({out_valid, in_ready, s, a_o, b_o} !== {1'b1, 1'b0, model_f(po, pa[0], pb[0]), pa[0], pb[0]}) begin
        fails++;
        $display("FAIL bp_hold cycle %0d got ov=%0b rdy=%0b s=%0d a_o=%0d b_o=%0d", c,
                 out_valid, in_ready, s, a_o, b_o);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      a = pa[i]; b = pb[i];
      tick();
      tests++;
      if ({out_valid, s, a_o, b_o} !== {1'b1, model_f(po, pa[i], pb[i]), pa[i], pb[i]}) begin
        fails++;
        $display("FAIL bp_order pair %0d got ov=%0b s=%0d a_o=%0d b_o=%0d want s=%0d a=%0d b=%0d",
                 i, out_valid, s, a_o, b_o, model_f(po, pa[i], pb[i]), pa[i], pb[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random_stream();
    logic [3*W-1:0] q [$];
    logic [3*W-1:0] held;
    logic           hold_chk;
    hold_chk = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 160; c++) begin
      in_valid  = (c < 150) ? ($urandom_range(3) != 0) : 1'b0;
      out_ready = (c < 150) ? ($urandom_range(2) != 0) : 1'b1;
      a = W'($urandom); b = W'($urandom); op = 3'($urandom);
      #1;
      if (hold_chk) begin
        tests++;
        if ({out_valid, s, a_o, b_o} !== {1'b1, held}) begin
          fails++; $display("FAIL rs_stall_stable cycle %0d got s=%0d a_o=%0d b_o=%0d", c, s, a_o, b_o);
        end
      end
      tests++;
      if (in_ready !== (!out_valid || out_ready)) begin
        fails++; $display("FAIL rs_in_ready cycle %0d got %0b", c, in_ready);
      end
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL rs_unexpected cycle %0d got s=%0d with nothing pending", c, s);
        end else if ({s, a_o, b_o} !== q[0]) begin
          fails++; $display("FAIL rs_data cycle %0d got %h want %h", c, {s, a_o, b_o}, q[0]);
          void'(q.pop_front());
        end else begin
          void'(q.pop_front());
        end
      end
      hold_chk = out_valid && !out_ready;
      held = {s, a_o, b_o};
      if (in_valid && in_ready) q.push_back({model_f(int'(op), a, b), a, b});
      tick();
    end
    tests++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rs_drain got %0d pending ov=%0b want 0 0", q.size(), out_valid);
    end
  endtask

  task automatic test_sweep(input int o, input int exp_sum, input bit stall,
                            input bit collide, input int restart_at);
    int k;
    bit seen_done;
    logic [W-1:0] ea, eb;
    op = 3'(o); start = 1'b1; in_valid = collide; a = W'($urandom); b = W'($urandom);
    out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL sw_start_in_ready op %0d got %0b want 0", o, in_ready);
    end
    tick();
    start = 1'b0; in_valid = 1'b0;
    tests++;
    if ({busy, out_valid, sum} !== {1'b1, 1'b0, {SUMW{1'b0}}}) begin
      fails++; $display("FAIL sw_entry op %0d got busy=%0b ov=%0b sum=%0d want 1 0 0", o, busy, out_valid, sum);
    end
    k = 0; seen_done = 1'b0;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      op = 3'($urandom);
      out_ready = stall ? ($urandom_range(1) == 1) : 1'b1;
      start = (k == restart_at);
      #1;
      if (out_valid && out_ready) begin
        ea = W'(k >> W); eb = W'(k % (1 << W));
        tests++;
        if (k >= 16 || {s, a_o, b_o} !== {model_f(o, ea, eb), ea, eb}) begin
          fails++; $display("FAIL sw_item op %0d idx %0d got s=%0d a_o=%0d b_o=%0d want s=%0d a=%0d b=%0d",
                            o, k, s, a_o, b_o, model_f(o, ea, eb), ea, eb);
        end
        k++;
      end
      tick();
      start = 1'b0;
      if (done) seen_done = 1'b1;
    end
    tests++;
    if (!seen_done) begin
      fails++; $display("FAIL sw_timeout op %0d no done after 400 cycles", o);
    end
    tests++;
    if (k != 16 || sum !== SUMW'(exp_sum) || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL sw_result op %0d got items=%0d sum=%0d busy=%0b ov=%0b want 16 %0d 0 0",
                        o, k, sum, busy, out_valid, exp_sum);
    end
    tick();
    tests++;
    if (done !== 1'b0 || sum !== SUMW'(exp_sum)) begin
      fails++; $display("FAIL sw_after op %0d got done=%0b sum=%0d want 0 %0d", o, done, sum, exp_sum);
    end
  endtask

  task automatic test_mid_reset();
    int k;
    int dones;
    op = 3'd0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; k = 0;
    for (int c = 0; c < 50 && k < 5; c++) begin
      if (out_valid) k++;
      if (k < 5) tick();
    end
    tests++;
    if (k != 5) begin
      fails++; $display("FAIL mr_progress got %0d outputs want 5", k);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, sum, busy, done, s} !== '0) begin
      fails++; $display("FAIL mr_abort got ov=%0b sum=%0d busy=%0b done=%0b s=%0d want 0",
                        out_valid, sum, busy, done, s);
    end
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done) dones++;
    end
    tests++;
    if (dones != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL mr_no_done got %0d done pulses busy=%0b want 0 0", dones, busy);
    end
    test_sweep(0, 8, 1'b0, 1'b0, -1);
  endtask

  initial begin
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0111; tt[3] = 4'b0001;
    tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0100; tt[7] = 4'b1011;
    test_reset();
    test_stream();
    test_backpressure();
    test_random_stream();
    test_sweep(0, 8, 1'b0, 1'b0, -1);
    test_sweep(4, 16, 1'b1, 1'b0, -1);
    test_sweep(1, 24, 1'b1, 1'b1, 7);
    test_sweep(3, 8, 1'b1, 1'b0, 3);
    test_sweep(7, 24, 1'b1, 1'b0, -1);
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
